// File: rtl/mips_muldiv_seq.sv
// Iterative MIPS HI/LO multiply/divide: 1 bit per cycle, WIDTH+2 edges accept-to-done, op_ready only in IDLE.
// MULDIV_EARLY_TERM_EN: multiplies leave RUN once the remaining multiplier bits are all zero.
module mips_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // mul: product accumulator; div: remainder in low bits
  logic [2*WIDTH-1:0] sh;    // mul: shifted multiplicand; div: divisor in low bits
  logic [WIDTH-1:0]   mq;    // mul: remaining multiplier; div: dividend in, quotient out
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     partial, diff, rem_nxt;
  logic               q_bit;
  logic               run_last;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign op_ready = (state == IDLE);
  assign busy     = (state == RUN) || (state == FIX);

  always_comb begin
    a_neg = ~op_code[0] & op_a[WIDTH-1];
    b_neg = ~op_code[0] & op_b[WIDTH-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
  end

  // Restoring step: shift the next dividend bit into the remainder and trial-subtract.
  always_comb begin
    partial = {acc[WIDTH-1:0], mq[WIDTH-1]};
    q_bit   = (partial >= {1'b0, sh[WIDTH-1:0]});
    diff    = partial - {1'b0, sh[WIDTH-1:0]};
    rem_nxt = q_bit ? diff : partial;
  end

`ifdef MULDIV_EARLY_TERM_EN
  assign run_last = (cnt == CW'(WIDTH-1)) || (!is_div && ((mq >> 1) == '0));
`else
  assign run_last = (cnt == CW'(WIDTH-1));
`endif

  always_comb begin
    prod   = neg_q ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_lo = neg_q ? -mq : mq;
      res_hi = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      sh          <= '0;
      mq          <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (clk_enable) begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (op_valid) begin
            case (op_code)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                if (op_code[1] && (op_b == '0)) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
                end else begin
                  state  <= RUN;
                  cnt    <= '0;
                  acc    <= '0;
                  is_div <= op_code[1];
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  sh     <= {{WIDTH{1'b0}}, (op_code[1] ? b_mag : a_mag)};
                  mq     <= op_code[1] ? a_mag : b_mag;
                end
              end
              3'b100:  hi <= op_a;
              3'b101:  lo <= op_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
              acc <= {{(WIDTH-1){1'b0}}, rem_nxt};
              mq  <= {mq[WIDTH-2:0], q_bit};
            end else begin
              acc <= acc + (mq[0] ? sh : '0);
              sh  <= sh << 1;
              mq  <= mq >> 1;
            end
            if (run_last) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!cancel) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule
